// File: rtl/ws_pixel_capture.sv
// WS2812-class pixel capture: deserialises decoded bits, claims the first NUM_PIXELS pixels
// of a frame, then forwards the line downstream. Optional macro: PIXCAP_PARTIAL_ERR_EN.
module ws_pixel_capture #(
  parameter  int BITS_PER_PIXEL = 24,
  parameter  int NUM_PIXELS     = 1,
  localparam int IDX_W          = $clog2(NUM_PIXELS + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_shift_en,
  input  logic                      i_decode_bit,
  input  logic                      i_treset,
  output logic [BITS_PER_PIXEL-1:0] o_pix_data,
  output logic [IDX_W-1:0]          o_pix_idx,
  output logic                      o_pix_valid,
  input  logic                      i_pix_ready,
  output logic                      o_passthru_en,
`ifdef PIXCAP_PARTIAL_ERR_EN
  output logic                      o_partial_err,
`endif
  output logic                      o_overflow
);

  localparam int CNT_W = $clog2(BITS_PER_PIXEL);

  typedef enum logic {CAPTURE, PASSTHRU} state_t;

  state_t                    state, state_next;
  logic [BITS_PER_PIXEL-2:0] sr;
  logic [CNT_W-1:0]          bit_cnt;
  logic [IDX_W-1:0]          pix_cnt;
  logic                      shift_bit, last_bit, last_pix;
  logic [BITS_PER_PIXEL-1:0] shifted;

  // A line reset always wins, so a bit strobed alongside it is dropped.
  assign shift_bit = i_shift_en && !i_treset && (state == CAPTURE);
  assign last_bit  = shift_bit && (bit_cnt == CNT_W'(BITS_PER_PIXEL - 1));
  assign last_pix  = (pix_cnt == IDX_W'(NUM_PIXELS - 1));
  assign shifted   = {sr, i_decode_bit};

  assign o_passthru_en = (state == PASSTHRU);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= CAPTURE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_treset)                state_next = CAPTURE;
    else if (last_bit && last_pix) state_next = PASSTHRU;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      pix_cnt <= '0;
    end else if (i_treset) begin
      sr      <= '0;
      bit_cnt <= '0;
      pix_cnt <= '0;
    end else if (shift_bit) begin
      sr <= shifted[BITS_PER_PIXEL-2:0];
      if (last_bit) begin
        bit_cnt <= '0;
        pix_cnt <= pix_cnt + 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Output slot: newest pixel wins; overwriting an unaccepted one is flagged sticky.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pix_data  <= '0;
      o_pix_idx   <= '0;
      o_pix_valid <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (last_bit) begin
        o_pix_data  <= shifted;
        o_pix_idx   <= pix_cnt;
        o_pix_valid <= 1'b1;
        if (o_pix_valid && !i_pix_ready) o_overflow <= 1'b1;
      end else if (o_pix_valid && i_pix_ready) begin
        o_pix_valid <= 1'b0;
      end
      if (i_treset) o_overflow <= 1'b0;
    end
  end

`ifdef PIXCAP_PARTIAL_ERR_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) o_partial_err <= 1'b0;
    else            o_partial_err <= i_treset && (state == CAPTURE) && (bit_cnt != '0);
  end
`endif

endmodule

// File: tb/tb_ws_pixel_capture.sv
// Bench for ws_pixel_capture: frame-level bit-queue model for a 24-bit/2-pixel instance,
// directed checks on a 32-bit/1-pixel instance. Honours PIXCAP_PARTIAL_ERR_EN when defined.
module tb_ws_pixel_capture;

  localparam int BPP = 24;
  localparam int NP  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n = 1'b0;
  logic            shift_en = 1'b0, decode_bit = 1'b0, treset = 1'b0, pix_ready = 1'b0;
  logic [BPP-1:0]  pix_data;
  logic [1:0]      pix_idx;
  logic            pix_valid, passthru_en, overflow;
  logic            partial_err;

  logic            reset32_n = 1'b0;
  logic            shift32 = 1'b0, bit32 = 1'b0, treset32 = 1'b0, ready32 = 1'b0;
  logic [31:0]     data32;
  logic [0:0]      idx32;
  logic            valid32, passthru32, overflow32, perr32;

  ws_pixel_capture #(.BITS_PER_PIXEL(BPP), .NUM_PIXELS(NP)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_shift_en(shift_en), .i_decode_bit(decode_bit),
    .i_treset(treset), .o_pix_data(pix_data), .o_pix_idx(pix_idx), .o_pix_valid(pix_valid),
    .i_pix_ready(pix_ready), .o_passthru_en(passthru_en),
`ifdef PIXCAP_PARTIAL_ERR_EN
    .o_partial_err(partial_err),
`endif
    .o_overflow(overflow)
  );

  ws_pixel_capture #(.BITS_PER_PIXEL(32), .NUM_PIXELS(1)) dut32 (
    .i_clk(clk), .i_reset_n(reset32_n), .i_shift_en(shift32), .i_decode_bit(bit32),
    .i_treset(treset32), .o_pix_data(data32), .o_pix_idx(idx32), .o_pix_valid(valid32),
    .i_pix_ready(ready32), .o_passthru_en(passthru32),
`ifdef PIXCAP_PARTIAL_ERR_EN
    .o_partial_err(perr32),
`endif
    .o_overflow(overflow32)
  );

`ifndef PIXCAP_PARTIAL_ERR_EN
  assign partial_err = 1'b0;
  assign perr32      = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: every bit accepted in the current frame, plus the output slot.
  bit          frame_bits[$];
  logic [31:0] m_data = '0;
  int          m_idx = 0;
  logic        m_valid = 1'b0, m_ovf = 1'b0, m_perr = 1'b0;

  function automatic logic m_pass();
    return frame_bits.size() >= BPP * NP;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic sh, input logic b, input logic tr, input logic rdy);
    logic pass_pre;
    int   n;
    pass_pre = m_pass();
    m_perr   = 1'b0;
    if (tr) begin
      if (!pass_pre && (frame_bits.size() % BPP) != 0) m_perr = 1'b1;
      frame_bits.delete();
      m_ovf = 1'b0;
      if (m_valid && rdy) m_valid = 1'b0;
    end else if (sh && !pass_pre && ((frame_bits.size() + 1) % BPP) == 0) begin
      frame_bits.push_back(b);
      n = frame_bits.size();
      if (m_valid && !rdy) m_ovf = 1'b1;
      m_data = '0;
      for (int k = n - BPP; k < n; k++) m_data = {m_data[30:0], frame_bits[k]};
      m_idx   = n / BPP - 1;
      m_valid = 1'b1;
    end else begin
      if (sh && !pass_pre) frame_bits.push_back(b);
      if (m_valid && rdy) m_valid = 1'b0;
    end
  endtask

  task automatic check_output();
    check("valid", 32'(pix_valid), 32'(m_valid));
    check("passthru", 32'(passthru_en), 32'(m_pass()));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef PIXCAP_PARTIAL_ERR_EN
    check("partial_err", 32'(partial_err), 32'(m_perr));
`endif
    if (m_valid) begin
      check("data", 32'(pix_data), m_data);
      check("idx", 32'(pix_idx), 32'(m_idx));
    end
  endtask

  task automatic apply_stimulus(input logic sh, input logic b, input logic tr, input logic rdy);
    shift_en = sh; decode_bit = b; treset = tr; pix_ready = rdy;
    @(posedge clk);
    model_step(sh, b, tr, rdy);
    #1;
    check_output();
    shift_en = 1'b0; treset = 1'b0;
  endtask

  task automatic send_pixel(input logic [BPP-1:0] v, input logic rdy);
    for (int i = BPP - 1; i >= 0; i--) apply_stimulus(1'b1, v[i], 1'b0, rdy);
  endtask

  task automatic send32(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      shift32 = 1'b1; bit32 = v[i];
      @(posedge clk); #1;
    end
    shift32 = 1'b0;
  endtask

  initial begin
    logic [BPP-1:0] pat;
    #2;
    check("reset_valid", 32'(pix_valid), 32'd0);
    check("reset_data", 32'(pix_data), 32'd0);
    check("reset_passthru", 32'(passthru_en), 32'd0);
    @(negedge clk); reset_n = 1'b1; reset32_n = 1'b1;

    $display("[TB] single pixel, ready high");
    send_pixel(24'hA5C3F0, 1'b1);
    check("t1_data", 32'(pix_data), 32'h00A5C3F0);
    check("t1_valid", 32'(pix_valid), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] two pixels then passthrough");
    send_pixel(24'h112233, 1'b1);
    send_pixel(24'h445566, 1'b1);
    check("t2_idx", 32'(pix_idx), 32'd1);
    check("t2_passthru", 32'(passthru_en), 32'd1);
    send_pixel(24'h778899, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
    send_pixel(24'h0F0F0F, 1'b1);
    check("t2_rearm_idx", 32'(pix_idx), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] overflow with ready low");
    send_pixel(24'h000001, 1'b0);
    send_pixel(24'h000002, 1'b0);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_data", 32'(pix_data), 32'h2);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_valid_kept", 32'(pix_valid), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] truncated pixel");
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    send_pixel(24'hFFFFFF, 1'b1);
    check("t4_data", 32'(pix_data), 32'h00FFFFFF);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] accept coincident with completion");
    send_pixel(24'h123456, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pat = 24'h654321;
    for (int i = BPP - 1; i >= 1; i--) apply_stimulus(1'b1, pat[i], 1'b0, 1'b0);
    apply_stimulus(1'b1, pat[0], 1'b0, 1'b1);
    check("t6_data", 32'(pix_data), 32'h00654321);
    check("t6_overflow", 32'(overflow), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++)
      apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) != 0));

    $display("[TB] 32-bit single-pixel instance");
    ready32 = 1'b0;
    send32(32'hDEADBEEF);
    check("t5_data", data32, 32'hDEADBEEF);
    check("t5_valid", 32'(valid32), 32'd1);
    check("t5_idx", 32'(idx32), 32'd0);
    check("t5_passthru", 32'(passthru32), 32'd1);
    treset32 = 1'b1; @(posedge clk); #1; treset32 = 1'b0;
    check("t5_rearm", 32'(passthru32), 32'd0);
    check("t5_valid_kept", 32'(valid32), 32'd1);
    for (int i = 0; i < 10; i++) begin
      shift32 = 1'b1; bit32 = 1'b1; @(posedge clk); #1;
    end
    shift32 = 1'b0;
    #2 reset32_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(valid32), 32'd0);
    check("t5_rst_data", data32, 32'd0);
    check("t5_rst_passthru", 32'(passthru32), 32'd0);
    check("t5_rst_overflow", 32'(overflow32), 32'd0);
    check("t5_rst_perr", 32'(perr32), 32'd0);
    @(negedge clk); reset32_n = 1'b1;
    send32(32'h0000_0001);
    check("t5_after_reset_data", data32, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
